uart_wb_regs: RTL and testbench

- Wishbone responder for the UART: the slave end of the wb_* bus that the bench master drives.
- Decodes an 8-bit, 3-bit-address 16550-style register map.
- Buffers TX/RX bytes in FIFOs between the bus and the serial cores.
- Generates the divisor-based baud_o tick and the int_o interrupt.

---
 rtl/uart_wb_regs_if.sv | 21 ++
 rtl/uart_wb_regs.sv | 169 ++++++++++++++++
 tb/tb_uart_wb_regs.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_wb_regs_if.sv
// rtl/uart_wb_regs_if.sv - Wishbone bus bundle between the bench master and the UART register slave
interface uart_wb_regs_if;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i;
  logic [3:0] wb_sel_i;
  logic       wb_stb_i;
  logic       wb_cyc_i;
  logic       wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/uart_wb_regs.sv
// rtl/uart_wb_regs.sv - 16550-style UART register file with TX/RX FIFOs, baud tick and interrupt
// Optional UART_LOOPBACK_EN adds MCR (adr4) with LOOP routing the TX FIFO into the RX FIFO.
module uart_wb_regs #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  uart_wb_regs_if.slave    wb,
  output logic             int_o,
  output logic             baud_o,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_err,
  output logic [7:0]       lcr_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic             ack_q, int_q, oe_q, fe_q;
  logic [7:0]       dat_q, lcr_q, dll_q, dlm_q, scr_q;
  logic [2:0]       ier_q;
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [AW-1:0]    tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0]    tx_cnt_q, rx_cnt_q;
  logic [DIV_W-1:0] baud_cnt_q, divisor;
  logic [7:0]       rdata, iir, lsr, mcr_rd;
  logic             loop_w;
  logic             unused_sel;

  assign unused_sel = ^wb.wb_sel_i;

  logic acc, rd, wr, dlab;
  assign acc  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign rd   = acc & ~wb.wb_we_i;
  assign wr   = acc & wb.wb_we_i;
  assign dlab = lcr_q[7];

  logic tx_empty, tx_full, rx_empty, rx_full;
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));

`ifdef UART_LOOPBACK_EN
  logic loop_q;
  assign loop_w = loop_q;
  assign mcr_rd = {3'b000, loop_q, 4'b0000};
`else
  assign loop_w = 1'b0;
  assign mcr_rd = 8'h00;
`endif

  // In loopback the transmitter core never sees data; the head moves straight into RX.
  logic lb_move, tx_pop, tx_push, rx_pop, rx_in_valid, rx_push;
  logic [7:0] rx_in_data;
  assign tx_valid    = ~tx_empty & ~loop_w;
  assign tx_data     = tx_empty ? 8'h00 : tx_mem[tx_rp_q];
  assign lb_move     = loop_w & ~tx_empty & ~rx_full;
  assign tx_pop      = (tx_valid & tx_ready) | lb_move;
  assign tx_push     = wr & (wb.wb_adr_i == 3'd0) & ~dlab & (~tx_full | tx_pop);
  assign rx_pop      = rd & (wb.wb_adr_i == 3'd0) & ~dlab & ~rx_empty;
  assign rx_in_valid = loop_w ? lb_move : rx_valid;
  assign rx_in_data  = loop_w ? tx_data : rx_data;
  assign rx_push     = rx_in_valid & (~rx_full | rx_pop);

  logic oe_set, fe_set, fcr_wr, tx_clr, rx_clr, lsr_rd, div_wr;
  assign oe_set = rx_valid & ~loop_w & rx_full & ~rx_pop;
  assign fe_set = rx_valid & ~loop_w & rx_err;
  assign fcr_wr = wr & (wb.wb_adr_i == 3'd2);
  assign tx_clr = fcr_wr & wb.wb_dat_i[2];
  assign rx_clr = fcr_wr & wb.wb_dat_i[1];
  assign lsr_rd = rd & (wb.wb_adr_i == 3'd5);
  assign div_wr = wr & dlab & (wb.wb_adr_i[2:1] == 2'b00);

  assign lsr = {1'b0, tx_empty & ~tx_valid, tx_empty, 1'b0, fe_q, 1'b0, oe_q, ~rx_empty};

  always_comb begin
    iir = 8'hC1;
    if (ier_q[2] & (oe_q | fe_q))  iir = 8'hC6;
    else if (ier_q[0] & ~rx_empty) iir = 8'hC4;
    else if (ier_q[1] & tx_empty)  iir = 8'hC2;
  end

  always_comb begin
    rdata = 8'h00;
    case (wb.wb_adr_i)
      3'd0: rdata = dlab ? dll_q : (rx_empty ? 8'h00 : rx_mem[rx_rp_q]);
      3'd1: rdata = dlab ? dlm_q : {5'b00000, ier_q};
      3'd2: rdata = iir;
      3'd3: rdata = lcr_q;
      3'd4: rdata = mcr_rd;
      3'd5: rdata = lsr;
      3'd7: rdata = scr_q;
      default: rdata = 8'h00;
    endcase
  end

  assign divisor = DIV_W'({dlm_q, dll_q});
  assign baud_o  = (divisor != '0) && (baud_cnt_q == divisor - DIV_W'(1));

  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wp_q] <= wb.wb_dat_i;
    if (rx_push) rx_mem[rx_wp_q] <= rx_in_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0; dat_q <= 8'h00; int_q <= 1'b0;
      lcr_q <= 8'h03; ier_q <= 3'b000; dll_q <= 8'h00; dlm_q <= 8'h00; scr_q <= 8'h00;
      oe_q <= 1'b0; fe_q <= 1'b0;
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
      baud_cnt_q <= '0;
`ifdef UART_LOOPBACK_EN
      loop_q <= 1'b0;
`endif
    end else begin
      ack_q <= acc;
      dat_q <= rd ? rdata : 8'h00;
      int_q <= ~iir[0];
      if (wr) begin
        case (wb.wb_adr_i)
          3'd0: if (dlab) dll_q <= wb.wb_dat_i;
          3'd1: if (dlab) dlm_q <= wb.wb_dat_i; else ier_q <= wb.wb_dat_i[2:0];
          3'd3: lcr_q <= wb.wb_dat_i;
`ifdef UART_LOOPBACK_EN
          3'd4: loop_q <= wb.wb_dat_i[4];
`endif
          3'd7: scr_q <= wb.wb_dat_i;
          default: ;
        endcase
      end
      // Setting an error in the same edge as the LSR read keeps it visible.
      oe_q <= oe_set | (oe_q & ~lsr_rd);
      fe_q <= fe_set | (fe_q & ~lsr_rd);

      if (tx_clr) begin
        tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      end else begin
        if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
        if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
        if (tx_push & ~tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
        else if (tx_pop & ~tx_push) tx_cnt_q <= tx_cnt_q - CW'(1);
      end

      if (rx_clr) begin
        rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
      end else begin
        if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
        if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
        if (rx_push & ~rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
        else if (rx_pop & ~rx_push) rx_cnt_q <= rx_cnt_q - CW'(1);
      end

      if (div_wr || divisor == '0 || baud_o) baud_cnt_q <= '0;
      else                                  baud_cnt_q <= baud_cnt_q + DIV_W'(1);
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign int_o       = int_q;
  assign lcr_o       = lcr_q;
endmodule

// File: tb/tb_uart_wb_regs.sv
// tb/tb_uart_wb_regs.sv - directed self-checking bench for uart_wb_regs
module tb_uart_wb_regs;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       int_w, baud_w, tx_valid_w;
  logic [7:0] tx_data_w, lcr_w;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err   = 1'b0;
  int tests = 0;
  int fails = 0;

  uart_wb_regs_if bus();

  uart_wb_regs #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
    .int_o(int_w), .baud_o(baud_w), .tx_data(tx_data_w), .tx_valid(tx_valid_w),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .lcr_o(lcr_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [2:0] a, input logic [7:0] d, input logic we, output logic [7:0] q);
    @(negedge clk);
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_we_i = we;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    q = bus.wb_dat_o;
    chk("ack", {15'd0, bus.wb_ack_o}, 16'd1);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(a, d, 1'b1, q);
    chk("wr_dat_zero", {8'd0, q}, 16'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] q;
    wb_xfer(a, 8'h00, 1'b0, q);
    chk(tag, {8'd0, q}, {8'd0, exp});
  endtask

  initial begin
    int pulses;
    int prev;
    int gap;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'hF; bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {15'd0, bus.wb_ack_o}, 16'd0);
    chk("rst_dat", {8'd0, bus.wb_dat_o}, 16'd0);
    chk("rst_int", {15'd0, int_w}, 16'd0);
    chk("rst_baud", {15'd0, baud_w}, 16'd0);
    chk("rst_txv", {15'd0, tx_valid_w}, 16'd0);
    chk("rst_txd", {8'd0, tx_data_w}, 16'd0);
    chk("rst_lcr", {8'd0, lcr_w}, 16'h03);
    @(negedge clk); rst = 1'b0;
    rd_chk("rst_lsr", 3'd5, 8'h60);
    rd_chk("rst_iir", 3'd2, 8'hC1);

    // reset landing in an ack cycle
    wr(3'd7, 8'h55);
    @(negedge clk);
    bus.wb_adr_i = 3'd7; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("mid_ack", {15'd0, bus.wb_ack_o}, 16'd1);
    chk("mid_scr", {8'd0, bus.wb_dat_o}, 16'h55);
    @(negedge clk); rst = 1'b1; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_ack_clr", {15'd0, bus.wb_ack_o}, 16'd0);
    @(negedge clk); rst = 1'b0;
    rd_chk("mid_lcr", 3'd3, 8'h03);
    rd_chk("mid_lsr", 3'd5, 8'h60);
    rd_chk("mid_scr0", 3'd7, 8'h00);

    // baud divisor 4
    wr(3'd3, 8'h83); wr(3'd0, 8'h04); wr(3'd1, 8'h00); wr(3'd3, 8'h03);
    pulses = 0; prev = -1; gap = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (baud_w) begin
        pulses++;
        if (prev >= 0) gap = i - prev;
        prev = i;
      end
    end
    chk("baud_pulses", 16'(pulses), 16'd4);
    chk("baud_gap", 16'(gap), 16'd4);
    wr(3'd3, 8'h83); wr(3'd0, 8'h00); wr(3'd3, 8'h03);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (baud_w) pulses++;
    end
    chk("baud_off", 16'(pulses), 16'd0);

    // TX path
    wr(3'd0, 8'hA5); wr(3'd0, 8'h5A);
    chk("tx_valid", {15'd0, tx_valid_w}, 16'd1);
    chk("tx_head", {8'd0, tx_data_w}, 16'hA5);
    rd_chk("tx_lsr_busy", 3'd5, 8'h00);
    @(negedge clk); tx_ready = 1'b1;
    chk("tx_first", {8'd0, tx_data_w}, 16'hA5);
    @(posedge clk); #1;
    chk("tx_second", {8'd0, tx_data_w}, 16'h5A);
    chk("tx_valid2", {15'd0, tx_valid_w}, 16'd1);
    @(posedge clk); #1;
    chk("tx_drained", {15'd0, tx_valid_w}, 16'd0);
    @(negedge clk); tx_ready = 1'b0;
    rd_chk("tx_lsr_idle", 3'd5, 8'h60);

    // RX overflow
    wr(3'd1, 8'h05);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'(i);
    end
    @(negedge clk); rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    rd_chk("ovf_iir", 3'd2, 8'hC6);
    chk("ovf_int", {15'd0, int_w}, 16'd1);
    rd_chk("ovf_lsr", 3'd5, 8'h63);
    rd_chk("ovf_lsr_clr", 3'd5, 8'h61);
    rd_chk("ovf_iir_dr", 3'd2, 8'hC4);
    for (int i = 0; i < 16; i++) rd_chk("ovf_rbr", 3'd0, 8'(i));
    rd_chk("ovf_lsr_empty", 3'd5, 8'h60);
    rd_chk("ovf_iir_none", 3'd2, 8'hC1);
    @(posedge clk); #1;
    chk("ovf_int_clr", {15'd0, int_w}, 16'd0);

    // FE set in the same edge as an LSR read
    @(negedge clk);
    bus.wb_adr_i = 3'd5; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    rx_valid = 1'b1; rx_err = 1'b1; rx_data = 8'h77;
    @(posedge clk); #1;
    chk("fe_lsr_pre", {8'd0, bus.wb_dat_o}, 16'h60);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; rx_valid = 1'b0; rx_err = 1'b0;
    rd_chk("fe_kept", 3'd5, 8'h69);
    rd_chk("fe_cleared", 3'd5, 8'h61);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'(8'h80 + i);
    end
    @(negedge clk); rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) wr(3'd0, 8'(8'h40 + i));
    chk("full_txv", {15'd0, tx_valid_w}, 16'd1);
    rd_chk("full_lsr", 3'd5, 8'h01);
    wr(3'd2, 8'h06);
    rd_chk("fcr_lsr", 3'd5, 8'h60);
    chk("fcr_txv", {15'd0, tx_valid_w}, 16'd0);
    rd_chk("fcr_rbr", 3'd0, 8'h00);

`ifdef UART_LOOPBACK_EN
    wr(3'd4, 8'h10);
    rd_chk("mcr", 3'd4, 8'h10);
    wr(3'd0, 8'h3C);
    chk("lb_txv", {15'd0, tx_valid_w}, 16'd0);
    @(posedge clk); #1;
    chk("lb_txv2", {15'd0, tx_valid_w}, 16'd0);
    rd_chk("lb_rbr", 3'd0, 8'h3C);
`else
    wr(3'd4, 8'h10);
    rd_chk("mcr_absent", 3'd4, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
